// File: rtl/mb_gates.sv
// mb_gates: registered bitwise gate set (and/or/xor/not/nand/nor/xnor).
// Define MB_GATES_INPUT_REG_EN to add an input register stage (latency 2).
module mb_gates #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] oand,
    output logic [WIDTH-1:0] oor,
    output logic [WIDTH-1:0] oxor,
    output logic [WIDTH-1:0] onot,
    output logic [WIDTH-1:0] onand,
    output logic [WIDTH-1:0] onor,
    output logic [WIDTH-1:0] oxnor
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;

`ifdef MB_GATES_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s <= '0;
            b_s <= '0;
        end else begin
            a_s <= a;
            b_s <= b;
        end
    end
`else
    assign a_s = a;
    assign b_s = b;
`endif

    // Reset forces zero even on the inverting outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            oand  <= '0;
            oor   <= '0;
            oxor  <= '0;
            onot  <= '0;
            onand <= '0;
            onor  <= '0;
            oxnor <= '0;
        end else begin
            oand  <= a_s & b_s;
            oor   <= a_s | b_s;
            oxor  <= a_s ^ b_s;
            onot  <= ~a_s;
            onand <= ~(a_s & b_s);
            onor  <= ~(a_s | b_s);
            oxnor <= ~(a_s ^ b_s);
        end
    end

endmodule

// File: tb/tb_mb_gates.sv
// tb_mb_gates: scoreboard bench driving a WIDTH=3 and a WIDTH=8 mb_gates.
// Latency follows MB_GATES_INPUT_REG_EN.
module tb_mb_gates;

`ifdef MB_GATES_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int             due;
        logic [6:0][7:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [6:0][2:0] o3;
    logic [6:0][7:0] o8;

    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Truth tables indexed by {a,b}: and, or, xor, not, nand, nor, xnor.
    localparam logic [6:0][3:0] TT = '{
        4'b1001, 4'b0001, 4'b0111, 4'b0011,
        4'b0110, 4'b1110, 4'b1000
    };

    always #5 clk = ~clk;

    mb_gates #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .a(a3), .b(b3),
        .oand(o3[0]), .oor(o3[1]), .oxor(o3[2]),
        .onot(o3[3]), .onand(o3[4]), .onor(o3[5]),
        .oxnor(o3[6])
    );

    mb_gates #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .oand(o8[0]), .oor(o8[1]), .oxor(o8[2]),
        .onot(o8[3]), .onand(o8[4]), .onor(o8[5]),
        .oxnor(o8[6])
    );

    function automatic logic [6:0][7:0] model(
        input logic [7:0] a, input logic [7:0] b
    );
        logic [6:0][7:0] r;
        logic [3:0] t;
        for (int g = 0; g < 7; g++) begin
            t = TT[g];
            for (int i = 0; i < 8; i++)
                r[g][i] = t[{a[i], b[i]}];
        end
        return r;
    endfunction

    task automatic step(
        input logic [7:0] a, input logic [7:0] b,
        input logic r, input string tag
    );
        exp_t e;
        a8 = a;
        b8 = b;
        a3 = a[2:0];
        b3 = b[2:0];
        rst = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            while (sb.size() > 0 && sb[$].due >= cyc)
                void'(sb.pop_back());
            e.due = cyc;
            e.r = '0;
        end else begin
            e.due = cyc + LAT - 1;
            e.r = model(a, b);
        end
        sb.push_back(e);
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            for (int g = 0; g < 7; g++) begin
                checks++;
                if (o3[g] !== e.r[g][2:0]) begin
                    errors++;
                    $display("FAIL %s w3 gate%0d cyc%0d got=%b want=%b",
                             tag, g, cyc, o3[g], e.r[g][2:0]);
                end
                checks++;
                if (o8[g] !== e.r[g]) begin
                    errors++;
                    $display("FAIL %s w8 gate%0d cyc%0d got=%h want=%h",
                             tag, g, cyc, o8[g], e.r[g]);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            step(8'd7, 8'd7, 1'b1, "reset");
    endtask

    task automatic test_basic();
        step(8'd0, 8'd1, 1'b0, "basic");
    endtask

    task automatic test_back_to_back();
        step(8'd2, 8'd3, 1'b0, "b2b");
        step(8'd4, 8'd5, 1'b0, "b2b");
    endtask

    task automatic test_corner();
        step(8'd6, 8'd7, 1'b0, "corner");
        step(8'd7, 8'd1, 1'b0, "corner");
    endtask

    task automatic test_mid_reset();
        step(8'd2, 8'd3, 1'b0, "midrst");
        step(8'd4, 8'd5, 1'b1, "midrst");
        step(8'd6, 8'd7, 1'b0, "midrst");
        step(8'd7, 8'd1, 1'b0, "midrst");
    endtask

    task automatic test_width8();
        step(8'hA5, 8'h0F, 1'b0, "w8");
        step(8'h5A, 8'hF0, 1'b0, "w8");
        step(8'hFF, 8'h00, 1'b0, "w8");
    endtask

    task automatic test_drain();
        for (int i = 0; i < LAT + 1; i++)
            step(8'd0, 8'd0, 1'b0, "drain");
        checks++;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL drain pending=%0d want<=1", sb.size());
        end
    endtask

    initial begin
        // Spot-check the model against hand-derived values.
        checks++;
        if (model(8'hA5, 8'h0F) !== {8'h55, 8'h50, 8'hFA, 8'h5A,
                                     8'hAA, 8'hAF, 8'h05}) begin
            errors++;
            $display("FAIL model_a5_0f got=%h", model(8'hA5, 8'h0F));
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_corner();
        test_mid_reset();
        test_width8();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
